// File: rtl/imem_pkg.sv
// Shared types and defaults for the instruction-memory server.
package imem_pkg;

   typedef enum logic [1:0] {
      ST_LOAD,
      ST_FLUSH,
      ST_RUN
   } imem_state_t;

   localparam int unsigned IMEM_ADDR_W   = 12;
   localparam logic [31:0] IMEM_NOP_WORD = 32'h0000_0000;
   localparam int unsigned IMEM_BCNT_W   = 2;

endpackage

// File: rtl/imem_ram.sv
// 2^ADDR_W x 32 synchronous RAM: one write port, one registered read port, array not reset.
module imem_ram
   import imem_pkg::*;
#(
   parameter int unsigned ADDR_W = IMEM_ADDR_W
) (
   input  logic              i_clk,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [31:0]       i_wdata,
   input  logic [ADDR_W-1:0] i_raddr,
   output logic [31:0]       o_rdata
);

   logic [31:0] r_mem [2**ADDR_W];
   logic [31:0] r_rdata;

   // Write-through so the padded word flushed on the RUN-entry edge is seen by that edge's read.
   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
      r_rdata <= (i_we && (i_waddr == i_raddr)) ? i_wdata : r_mem[i_raddr];
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/imem_server.sv
// Boot-loading instruction memory: LOAD packs bytes into words, FLUSH writes any partial word, RUN serves reads.
// Optional out-of-range read detection is enabled with `define IMEM_BOUNDS_CHECK_EN.
module imem_server
   import imem_pkg::*;
#(
   parameter int unsigned ADDR_W   = IMEM_ADDR_W,
   parameter logic [31:0] NOP_WORD = IMEM_NOP_WORD
) (
   input  logic        clock,
   input  logic        clr_n,
   input  logic [31:0] address,
   output logic [31:0] q,
   output logic        q_valid,
   output logic        cpu_en,
   input  logic [7:0]  ld_byte,
   input  logic        ld_valid,
   input  logic        ld_last,
   output logic        ld_ready,
   output logic        ld_overflow,
   output logic        addr_fault
);

   imem_state_t            r_state;
   logic                   r_ld_ready;
   logic                   r_cpu_en;
   logic                   r_q_valid;
   logic                   r_ld_overflow;
   logic [ADDR_W-1:0]      r_wr_ptr;
   logic                   r_full;
   logic [IMEM_BCNT_W-1:0] r_bcnt;
   logic [23:0]            r_word;

   logic                   w_acc;
   logic                   w_wr_req;
   logic                   w_we;
   logic [31:0]            w_wdata;
   logic [31:0]            w_rdata;
   logic                   w_fault;

   always_comb begin
      w_acc    = (r_state == ST_LOAD) && r_ld_ready && ld_valid;
      w_wr_req = 1'b0;
      w_wdata  = {ld_byte, r_word};
      if (w_acc && (r_bcnt == '1)) begin
         w_wr_req = 1'b1;
      end else if ((r_state == ST_FLUSH) && (r_bcnt != '0)) begin
         w_wr_req = 1'b1;
         w_wdata  = {8'h00, r_word};
      end
      w_we = w_wr_req && !r_full;
   end

   // r_full marks that the last address has been written; any further write is an overflow.
   always_ff @(posedge clock or negedge clr_n) begin
      if (!clr_n) begin
         r_state       <= ST_LOAD;
         r_ld_ready    <= 1'b0;
         r_cpu_en      <= 1'b0;
         r_q_valid     <= 1'b0;
         r_ld_overflow <= 1'b0;
         r_wr_ptr      <= '0;
         r_full        <= 1'b0;
         r_bcnt        <= '0;
         r_word        <= '0;
      end else begin
         if (w_wr_req) begin
            if (r_full) begin
               r_ld_overflow <= 1'b1;
            end else if (r_wr_ptr == '1) begin
               r_full <= 1'b1;
            end else begin
               r_wr_ptr <= r_wr_ptr + 1'b1;
            end
         end
         case (r_state)
            ST_LOAD: begin
               r_ld_ready <= 1'b1;
               if (w_acc) begin
                  if (r_bcnt == '1) begin
                     r_bcnt <= '0;
                     r_word <= '0;
                  end else begin
                     r_word[8*r_bcnt +: 8] <= ld_byte;
                     r_bcnt                <= r_bcnt + 1'b1;
                  end
                  if (ld_last) begin
                     r_state    <= ST_FLUSH;
                     r_ld_ready <= 1'b0;
                  end
               end
            end
            ST_FLUSH: begin
               r_bcnt     <= '0;
               r_word     <= '0;
               r_ld_ready <= 1'b0;
               r_cpu_en   <= 1'b1;
               r_q_valid  <= 1'b1;
               r_state    <= ST_RUN;
            end
            ST_RUN: begin
               r_ld_ready <= 1'b0;
               r_cpu_en   <= 1'b1;
               r_q_valid  <= 1'b1;
            end
            default: begin
               r_state <= ST_LOAD;
            end
         endcase
      end
   end

   imem_ram #(
      .ADDR_W (ADDR_W)
   ) u_ram (
      .i_clk   (clock),
      .i_we    (w_we),
      .i_waddr (r_wr_ptr),
      .i_wdata (w_wdata),
      .i_raddr (address[ADDR_W-1:0]),
      .o_rdata (w_rdata)
   );

`ifdef IMEM_BOUNDS_CHECK_EN
   logic r_fault;
   logic w_oob;
   logic w_serve;

   assign w_oob   = |address[31:ADDR_W];
   assign w_serve = (r_state == ST_FLUSH) || (r_state == ST_RUN);

   always_ff @(posedge clock or negedge clr_n) begin
      if (!clr_n) begin
         r_fault <= 1'b0;
      end else begin
         r_fault <= w_serve && w_oob;
      end
   end

   assign w_fault = r_fault;
`else
   logic w_unused_addr_hi;

   assign w_unused_addr_hi = ^address[31:ADDR_W];
   assign w_fault          = 1'b0;
`endif

   assign q           = (r_q_valid && !w_fault) ? w_rdata : NOP_WORD;
   assign q_valid     = r_q_valid;
   assign cpu_en      = r_cpu_en;
   assign ld_ready    = r_ld_ready;
   assign ld_overflow = r_ld_overflow;
   assign addr_fault  = w_fault;

endmodule

// File: tb/tb_imem_server.sv
// Scoreboarded bench for imem_server: one stimulus stream drives a 4096-word and a 4-word instance.
module tb_imem_server;
   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] data;
      logic        fault;
   } exp_t;

   logic        clock = 1'b0;
   logic        clr_n;
   logic [31:0] address;
   logic [7:0]  ld_byte;
   logic        ld_valid;
   logic        ld_last;

   logic [31:0] qa, qb;
   logic        qva, qvb, cea, ceb, lra, lrb, ova, ovb, afa, afb;

   int   n_vec = 0;
   int   n_err = 0;
   exp_t sbA[$];
   exp_t sbB[$];
   logic [31:0] mA [4096];
   logic [31:0] mB [4];
   logic [31:0] ovfB_exp = 32'd0;
   logic [7:0]  bq[$];

   always #5 clock = ~clock;

   imem_server #(.ADDR_W(12), .NOP_WORD(NOP)) u_a (
      .clock(clock), .clr_n(clr_n), .address(address), .q(qa), .q_valid(qva),
      .cpu_en(cea), .ld_byte(ld_byte), .ld_valid(ld_valid), .ld_last(ld_last),
      .ld_ready(lra), .ld_overflow(ova), .addr_fault(afa)
   );

   imem_server #(.ADDR_W(2), .NOP_WORD(NOP)) u_b (
      .clock(clock), .clr_n(clr_n), .address(address), .q(qb), .q_valid(qvb),
      .cpu_en(ceb), .ld_byte(ld_byte), .ld_valid(ld_valid), .ld_last(ld_last),
      .ld_ready(lrb), .ld_overflow(ovb), .addr_fault(afb)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   function automatic exp_t expA(input logic [31:0] a);
      exp_t e;
      e.data  = mA[a[11:0]];
      e.fault = 1'b0;
`ifdef IMEM_BOUNDS_CHECK_EN
      if (a[31:12] != 20'd0) begin
         e.data  = NOP;
         e.fault = 1'b1;
      end
`endif
      return e;
   endfunction

   function automatic exp_t expB(input logic [31:0] a);
      exp_t e;
      e.data  = mB[a[1:0]];
      e.fault = 1'b0;
`ifdef IMEM_BOUNDS_CHECK_EN
      if (a[31:2] != 30'd0) begin
         e.data  = NOP;
         e.fault = 1'b1;
      end
`endif
      return e;
   endfunction

   task automatic model_load(input logic [7:0] b[$]);
      int n;
      n = b.size();
      for (int w = 0; w * 4 < n; w++) begin
         logic [31:0] v;
         v = '0;
         for (int k = 0; k < 4; k++) begin
            if (w * 4 + k < n) v[8*k +: 8] = b[w*4+k];
         end
         if (w < 4096) mA[w] = v;
         if (w < 4) mB[w] = v;
         else ovfB_exp = 32'd1;
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_qA"}, qa, NOP);
      chk({tag, "_qB"}, qb, NOP);
      chk({tag, "_qvA"}, {31'd0, qva}, 32'd0);
      chk({tag, "_qvB"}, {31'd0, qvb}, 32'd0);
      chk({tag, "_ceA"}, {31'd0, cea}, 32'd0);
      chk({tag, "_ceB"}, {31'd0, ceb}, 32'd0);
      chk({tag, "_lrA"}, {31'd0, lra}, 32'd0);
      chk({tag, "_lrB"}, {31'd0, lrb}, 32'd0);
      chk({tag, "_ovA"}, {31'd0, ova}, 32'd0);
      chk({tag, "_ovB"}, {31'd0, ovb}, 32'd0);
      chk({tag, "_afA"}, {31'd0, afa}, 32'd0);
      chk({tag, "_afB"}, {31'd0, afb}, 32'd0);
   endtask

   task automatic do_reset();
      clr_n    = 1'b0;
      ld_valid = 1'b0;
      ld_last  = 1'b0;
      ld_byte  = 8'h00;
      address  = 32'd0;
      ovfB_exp = 32'd0;
      #1;
      chk_idle("rst");
      tick();
      clr_n = 1'b1;
      tick();
      chk("rdyA_after_rst", {31'd0, lra}, 32'd1);
      chk("rdyB_after_rst", {31'd0, lrb}, 32'd1);
   endtask

   task automatic send(input logic [7:0] b[$], input bit gaps, input bit with_last);
      for (int i = 0; i < b.size(); i++) begin
         if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
               ld_valid = 1'b0;
               ld_byte  = 8'($urandom);
               ld_last  = 1'($urandom_range(0, 1));
               tick();
            end
         end
         chk("rdyA_load", {31'd0, lra}, 32'd1);
         chk("rdyB_load", {31'd0, lrb}, 32'd1);
         ld_valid = 1'b1;
         ld_byte  = b[i];
         ld_last  = with_last && (i == b.size() - 1);
         tick();
      end
      ld_valid = 1'b0;
      ld_last  = 1'b0;
   endtask

   task automatic pop_check(input string tag);
      exp_t ea, eb;
      ea = sbA.pop_front();
      eb = sbB.pop_front();
      chk({tag, "_qA"}, qa, ea.data);
      chk({tag, "_qB"}, qb, eb.data);
      chk({tag, "_qvA"}, {31'd0, qva}, 32'd1);
      chk({tag, "_qvB"}, {31'd0, qvb}, 32'd1);
      chk({tag, "_afA"}, {31'd0, afa}, {31'd0, ea.fault});
      chk({tag, "_afB"}, {31'd0, afb}, {31'd0, eb.fault});
   endtask

   // Called just after the edge that accepted the last byte (FLUSH cycle).
   task automatic finish_load();
      chk("flush_lrA", {31'd0, lra}, 32'd0);
      chk("flush_lrB", {31'd0, lrb}, 32'd0);
      chk("flush_ceA", {31'd0, cea}, 32'd0);
      chk("flush_qvA", {31'd0, qva}, 32'd0);
      chk("flush_qA", qa, NOP);
      address = 32'd0;
      sbA.push_back(expA(address));
      sbB.push_back(expB(address));
      tick();
      chk("run_ceA", {31'd0, cea}, 32'd1);
      chk("run_ceB", {31'd0, ceb}, 32'd1);
      chk("run_lrA", {31'd0, lra}, 32'd0);
      pop_check("entry");
   endtask

   task automatic run_read(input logic [31:0] a);
      ld_valid = 1'($urandom_range(0, 1));
      ld_byte  = 8'($urandom);
      address  = a;
      sbA.push_back(expA(a));
      sbB.push_back(expB(a));
      tick();
      pop_check("read");
      chk("read_lrA", {31'd0, lra}, 32'd0);
      chk("read_lrB", {31'd0, lrb}, 32'd0);
      chk("read_ovB", {31'd0, ovb}, ovfB_exp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
      $fatal(1);
   end

   initial begin
      clr_n    = 1'b0;
      address  = 32'd0;
      ld_byte  = 8'h00;
      ld_valid = 1'b0;
      ld_last  = 1'b0;
      repeat (2) tick();
      chk_idle("por");
      clr_n = 1'b1;
      chk_idle("rel");
      tick();
      chk("rdyA_first_edge", {31'd0, lra}, 32'd1);
      chk("rdyB_first_edge", {31'd0, lrb}, 32'd1);

      // Basic 8-byte load
      bq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
      model_load(bq);
      send(bq, 1'b0, 1'b1);
      finish_load();
      run_read(32'd1);
      run_read(32'd0);
      run_read(32'd1);

      // Partial final word with idle gaps, then bounds/alias reads
      do_reset();
      bq = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
      model_load(bq);
      send(bq, 1'b1, 1'b1);
      finish_load();
      run_read(32'd1);
      run_read(32'd0);
      run_read(32'h0000_1000);
      run_read(32'd0);
      run_read(32'hFFFF_F001);
      run_read(32'd1);

      // Reset mid-load discards the pending bytes
      do_reset();
      bq = '{8'h99, 8'h98, 8'h97};
      send(bq, 1'b0, 1'b0);
      do_reset();
      bq = '{8'h11, 8'h22, 8'h33, 8'h44};
      model_load(bq);
      send(bq, 1'b0, 1'b1);
      finish_load();
      run_read(32'd0);
      run_read(32'd1);

      // 20-byte image overflows the 4-word instance only
      do_reset();
      bq.delete();
      for (int i = 1; i <= 20; i++) bq.push_back(8'(i));
      model_load(bq);
      send(bq, 1'b1, 1'b1);
      chk("ovf_B", {31'd0, ovb}, 32'd1);
      chk("ovf_A", {31'd0, ova}, 32'd0);
      finish_load();
      for (int a = 0; a < 5; a++) run_read(32'(a));
      chk("ovf_B_sticky", {31'd0, ovb}, 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/imem_server.md
# imem_server

Instruction-memory responder for the fetch stage: accepts the word address presented by fetch each cycle and returns the 32-bit instruction one clock later. At power-up it first runs a boot-load phase, assembling a byte stream into words and writing them from address 0 upward. While loading it holds the processor stalled through `cpu_en`; once the image is loaded it switches to serving reads.

## Interface
Parameters:
- `ADDR_W`, 12: word-address width; depth = 2^ADDR_W words.
- `NOP_WORD`, 32'h0000_0000: value driven on `q` when no valid instruction is available.

Ports:
- `clock`  in  1: single clock, rising edge.
- `clr_n`  in  1: asynchronous, active-low reset.
- `address`  in  32: word address from fetch (PC, increments by 1 per instruction).
- `q`  out  32: instruction for the address sampled on the previous edge.
- `q_valid`  out  1: `q` holds a served read.
- `cpu_en`  out  1: drives the fetch/PC enable; low during reset and load.
- `ld_byte`  in  8: boot-image byte.
- `ld_valid`  in  1: `ld_byte` is valid.
- `ld_last`  in  1: qualifies the final byte of the image.
- `ld_ready`  out  1: loader can accept a byte this cycle.
- `ld_overflow`  out  1: sticky; the image exceeded the memory depth.
- `addr_fault`  out  1: one-cycle pulse for an out-of-range read (only with the macro set).

## Operation
- States: LOAD → FLUSH → RUN. Reset enters LOAD. RUN is terminal until the next reset.
- **LOAD**
  - `ld_ready`=1.
  - Byte accepted when `ld_valid && ld_ready`.
  - Bytes pack little-endian: first byte → [7:0], fourth → [31:24].
  - On the 4th byte, the word is written at `wr_ptr`; `wr_ptr`++ and the byte counter clears.
  - Accepted byte with `ld_last`=1 → FLUSH.
- **FLUSH** (exactly 1 cycle)
  - `ld_ready`=0.
  - If a partial word is pending (1–3 bytes), it is zero-padded in the upper bytes and written at `wr_ptr`.
  - If the last byte completed a word, no extra write occurs.
  - Then → RUN.
- **Overflow**
  - When `wr_ptr` would exceed 2^ADDR_W−1, the write is discarded and `ld_overflow` sets.
  - `wr_ptr` saturates and does not wrap.
  - Loading continues to `ld_last` so the stream drains.
- **RUN**
  - `cpu_en`=1, `ld_ready`=0; `ld_valid` is ignored.
  - Every cycle, `address[ADDR_W-1:0]` is read.
- Memory contents are not cleared by reset. Words never written read as undefined.

## Timing
- **Reset values:** `q`=NOP_WORD, `q_valid`=0, `cpu_en`=0, `ld_ready`=0, `ld_overflow`=0, `addr_fault`=0, `wr_ptr`=0, byte count=0.
- `ld_ready` rises on the first edge after `clr_n` deasserts.
- **Read latency:** 1 cycle. `address` sampled at edge N appears on `q` after edge N, with `q_valid`=1 from the first RUN edge onward.
- In LOAD/FLUSH, `q`=NOP_WORD and `q_valid`=0.
- `cpu_en` rises on the edge entering RUN. The first read served is the address present on that edge.
- **Load write timing:** the write lands on the same edge the 4th byte is accepted. A read of that word in RUN is therefore always safe.
- **Reset mid-load:**
  - Pending byte count and `wr_ptr` are discarded; return to LOAD.
  - Memory words already written persist but are overwritten by the new load.
- Throughput: one byte per cycle in LOAD; one read per cycle in RUN.

## Configuration
- Macro: `IMEM_BOUNDS_CHECK_EN`.
- **Defined:**
  - In RUN, `address[31:ADDR_W]` ≠ 0 → `q`=NOP_WORD (with `q_valid`=1) on the next cycle, and `addr_fault` pulses high for that cycle.
  - In-range reads are unaffected.
- **Undefined:**
  - Upper address bits are ignored; the address aliases modulo 2^ADDR_W.
  - `addr_fault` is tied 0.

## Structure
- Package `imem_pkg`:
  - state enum {LOAD, FLUSH, RUN}
  - default `ADDR_W`
  - `NOP_WORD`
  - byte-count width constant
- Sub-module `imem_ram`:
  - 2^ADDR_W × 32 synchronous RAM, one write port and one registered read port, no reset on the array.
  - `imem_server` holds the FSM, byte packer, `wr_ptr`, overflow flag and bounds check.

## Test plan
- **Basic load:** stream 8 bytes 01..08, `ld_last` on 08 → words 0x04030201 at addr 0 and 0x08070605 at addr 1. `cpu_en` rises 2 edges after the last byte (FLUSH, then RUN). Reads return those words one cycle after the address is driven.
- **Partial final word:** 5 bytes AA,BB,CC,DD,EE with last → addr 1 = 0x000000EE, written in the FLUSH cycle.
- **Back-pressure gaps:** `ld_valid` toggled randomly → packing is unaffected by idle cycles; `ld_ready` is 0 in FLUSH and RUN.
- **Overflow:** ADDR_W=2, stream 20 bytes → `ld_overflow`=1. Addresses 0–3 hold the first 16 bytes; `cpu_en` still rises after `ld_last`.
- **Reset mid-load:** pull `clr_n` low after 3 bytes, then reload 4 bytes 11,22,33,44 → addr 0 = 0x44332211.
- **Bounds check:** with `IMEM_BOUNDS_CHECK_EN`, drive address 0x0000_1000 (ADDR_W=12) → next cycle `q`=NOP_WORD and `addr_fault`=1 for one cycle. Without the macro, the same address returns the word at addr 0.
